// File: rtl/rstseq.sv
// rstseq: ordered reset release sequencer with soft/external reset sources and a saturating event counter.
module rstseq #(
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               soft_req,
  input  logic               ext_rst,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic               busy,
  output logic               soft_ack,
  output logic [CNT_W-1:0]   rst_count
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  state_t r_state, w_state;
  logic [HW-1:0] r_hold, w_hold;
  logic [SW-1:0] r_step, w_step;
  logic [NUM_OUT-1:0] r_rst_out, w_rst_out, w_shift;
  logic r_ready, w_ready, r_busy, r_soft_ack, r_ext_q, r_srst_q;
  logic [CNT_W-1:0] r_count;
  logic w_src, w_evt;
  assign w_src   = soft_req | ext_rst;
  assign w_evt   = soft_req | (ext_rst & ~r_ext_q);
  // Outputs release strictly in bit order, so each release is a left shift.
  assign w_shift = r_rst_out << 1;
  always_comb begin
    w_state   = r_state;
    w_hold    = r_hold;
    w_step    = r_step;
    w_rst_out = r_rst_out;
    w_ready   = r_ready;
    if (w_src) begin
      w_state   = HOLD;
      w_hold    = '0;
      w_rst_out = '1;
      w_ready   = 1'b0;
    end else if (r_state == HOLD && !r_srst_q) begin
      if (r_hold == HOLD_LAST) begin
        w_rst_out = w_shift;
        w_step    = '0;
        w_ready   = w_shift == '0;
        w_state   = w_shift == '0 ? RUN : RELEASE;
      end else begin
        w_hold = r_hold + 1'b1;
      end
    end else if (r_state == RELEASE) begin
      if (r_step == STEP_LAST) begin
        w_step    = '0;
        w_rst_out = w_shift;
        w_ready   = w_shift == '0;
        w_state   = w_shift == '0 ? RUN : RELEASE;
      end else begin
        w_step = r_step + 1'b1;
      end
    end
  end
  // The first edge after srst only arms the hold counter, so release timing counts from that edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state    <= HOLD;
      r_hold     <= '0;
      r_step     <= '0;
      r_rst_out  <= '1;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
      r_soft_ack <= 1'b0;
      r_count    <= '0;
      r_ext_q    <= 1'b1;
      r_srst_q   <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_hold     <= w_hold;
      r_step     <= w_step;
      r_rst_out  <= w_rst_out;
      r_ready    <= w_ready;
      r_busy     <= ~w_ready;
      r_soft_ack <= soft_req;
      r_count    <= (w_evt && !(&r_count)) ? r_count + 1'b1 : r_count;
      r_ext_q    <= ext_rst;
      r_srst_q   <= 1'b0;
    end
  end
  assign rst_out   = r_rst_out;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign soft_ack  = r_soft_ack;
  assign rst_count = r_count;
endmodule
